// File: rtl/dht11_responder.sv
// rtl/dht11_responder.sv - DHT11 sensor emulator: answers a host start pulse with presence pulse and 40-bit frame
// Optional feature macro DHT_RESP_CKSUM_ERR_EN adds cksum_err, which inverts the transmitted checksum.
module dht11_responder #(
    parameter int CLK_MHZ       = 50,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dht_in,
    output logic       dht_oe,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT_RESP_CKSUM_ERR_EN
    input  logic       cksum_err,
`endif
    output logic       busy,
    output logic       frame_done
);

    localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_MHZ - 1);
    localparam logic [14:0]   US_MAX    = 15'h7fff;
    localparam logic [14:0]   START_MIN = 15'(START_MIN_US);
    localparam logic [14:0]   RESP_DLY  = 15'(RESP_DELAY_US);

    typedef enum logic [2:0] {
        IDLE, START_LOW, WAIT_REL, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [14:0]   us_q, us_d;
    logic [39:0]   shift_q, shift_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic          dht_oe_q, dht_oe_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          tick, rise, fall, cksum_inv;
    logic [7:0]    cksum;

    assign tick  = (pre_q == PRE_MAX);
    assign rise  = sync2_q & ~prev_q;
    assign fall  = ~sync2_q & prev_q;
    assign cksum = hum_int + hum_dec + temp_int + temp_dec;

`ifdef DHT_RESP_CKSUM_ERR_EN
    assign cksum_inv = cksum_err;
`else
    assign cksum_inv = 1'b0;
`endif

    // True on the last clock of a d-microsecond stay, so each state lasts exactly d*CLK_MHZ cycles.
    function automatic logic expired(input logic t, input logic [14:0] us, input logic [14:0] d);
        return t && (us == d - 15'd1);
    endfunction

    always_comb begin
        state_d      = state_q;
        pre_d        = tick ? '0 : pre_q + 1'b1;
        us_d         = (tick && us_q != US_MAX) ? us_q + 15'd1 : us_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE:      if (fall) state_d = START_LOW;
            START_LOW: begin
                if (rise) begin
                    if (us_q >= START_MIN) begin
                        state_d   = WAIT_REL;
                        shift_d   = {hum_int, hum_dec, temp_int, temp_dec, cksum ^ {8{cksum_inv}}};
                        bit_cnt_d = 6'd39;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_REL:  if (expired(tick, us_q, RESP_DLY)) state_d = RESP_LOW;
            RESP_LOW:  if (expired(tick, us_q, 15'd80)) state_d = RESP_HIGH;
            RESP_HIGH: if (expired(tick, us_q, 15'd80)) state_d = BIT_LOW;
            BIT_LOW:   if (expired(tick, us_q, 15'd50)) state_d = BIT_HIGH;
            BIT_HIGH: begin
                if (expired(tick, us_q, shift_q[39] ? 15'd70 : 15'd26)) begin
                    if (bit_cnt_q == 6'd0) begin
                        state_d = END_LOW;
                    end else begin
                        state_d   = BIT_LOW;
                        bit_cnt_d = bit_cnt_q - 6'd1;
                        shift_d   = {shift_q[38:0], 1'b0};
                    end
                end
            end
            END_LOW: begin
                if (expired(tick, us_q, 15'd50)) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default:   state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            pre_d = '0;
            us_d  = '0;
        end
        // Outputs follow the next state so they change on the same edge as the state register.
        dht_oe_d = (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
        busy_d   = (state_d != IDLE) && (state_d != START_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            pre_q        <= '0;
            us_q         <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            dht_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= dht_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            pre_q        <= pre_d;
            us_q         <= us_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            dht_oe_q     <= dht_oe_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dht_oe     = dht_oe_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dht11_responder.sv
// tb/tb_dht11_responder.sv - self-checking bench for dht11_responder
// Scaled timing (2 MHz, 200 us start minimum) keeps every frame short.
module tb_dht11_responder;

    localparam int CLK      = 2;
    localparam int START_US = 200;
    localparam int DLY_US   = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_low = 1'b0;
    logic       dht_in, dht_oe, busy, frame_done;
    logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
`ifdef DHT_RESP_CKSUM_ERR_EN
    logic       cksum_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // Open-drain line with pull-up: low when either end drives it.
    assign dht_in = ~(dht_oe | host_low);

    dht11_responder #(.CLK_MHZ(CLK), .START_MIN_US(START_US), .RESP_DELAY_US(DLY_US)) dut (
        .clk(clk), .rst_n(rst_n), .dht_in(dht_in), .dht_oe(dht_oe),
        .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
`ifdef DHT_RESP_CKSUM_ERR_EN
        .cksum_err(cksum_err),
`endif
        .busy(busy), .frame_done(frame_done)
    );

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_chk = 0, n_fail = 0;
    logic        arm = 1'b0, arm_d = 1'b0;
    logic [39:0] exp_word, dec_word;
    longint      t_rel = 0, t_last = 0;
    int          exp_q[$];
    int          seg = 0, n70 = 0, done_cnt = 0, act_cnt = 0, done_before = 0;
    logic        oe_d = 1'b0, busy_d = 1'b0, fd_d = 1'b0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame content from the protocol rules: four bytes then their mod-256 sum.
    function automatic logic [39:0] model_word(input logic [7:0] a, b, c, d, input bit err);
        int s;
        logic [7:0] ck;
        s  = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        ck = err ? ~8'(s) : 8'(s);
        return {a, b, c, d, ck};
    endfunction

    task automatic monitor();
        longint dur;
        int e, tol;
        bit b;
        forever begin
            @(negedge clk);
            if (arm && !arm_d) begin
                exp_q.delete();
                exp_q.push_back(DLY_US * CLK);
                exp_q.push_back(80 * CLK);
                exp_q.push_back(80 * CLK);
                for (int i = 39; i >= 0; i--) begin
                    exp_q.push_back(50 * CLK);
                    exp_q.push_back((exp_word[i] ? 70 : 26) * CLK);
                end
                exp_q.push_back(50 * CLK);
                seg = 0; dec_word = '0; n70 = 0;
            end
            arm_d = arm;
            if (rst_n) begin
                if (busy || dht_oe) act_cnt++;
                if (dht_oe) check(busy, "oe_implies_busy", busy, 1);
                if (frame_done) begin
                    done_cnt++;
                    check(!fd_d && busy_d && !busy, "done_pulse_busy_fall", {fd_d, busy_d, busy}, 3'b010);
                end
                if (arm && dht_oe != oe_d) begin
                    dur    = (seg == 0) ? cyc - t_rel : cyc - t_last;
                    t_last = cyc;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "extra_edge", seg, 84);
                    end else begin
                        e   = exp_q.pop_front();
                        tol = (seg == 0) ? CLK + 3 : CLK + 1;
                        check(dur >= e - tol && dur <= e + tol, $sformatf("seg_width[%0d]", seg), dur, e);
                        if (seg >= 4 && seg <= 82 && seg % 2 == 0) begin
                            b = (dur > 48 * CLK);
                            dec_word = {dec_word[38:0], b};
                            if (b) n70++;
                        end
                        if (seg == 83) check(frame_done, "done_at_end_low", frame_done, 1);
                    end
                    seg++;
                end
            end
            oe_d = dht_oe; busy_d = busy; fd_d = frame_done;
        end
    endtask

    task automatic set_bytes(input logic [7:0] a, b, c, d);
        hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
    endtask

    task automatic host_start(input int low_us);
        @(negedge clk);
        host_low = 1'b1;
        repeat (low_us * CLK) @(negedge clk);
        host_low = 1'b0;
        t_rel = cyc;
    endtask

    task automatic start_frame(input logic [7:0] a, b, c, d, input bit err);
        set_bytes(a, b, c, d);
`ifdef DHT_RESP_CKSUM_ERR_EN
        cksum_err = err;
`endif
        exp_word    = model_word(a, b, c, d, err);
        done_before = done_cnt;
        arm         = 1'b1;
        host_start(250);
    endtask

    task automatic wait_seg(input int n);
        int k = 0;
        while (seg < n && k < 12000) begin @(negedge clk); k++; end
        check(seg >= n, "reach_seg", seg, n);
    endtask

    task automatic finish_frame(input logic [39:0] lit, input string nm);
        int k = 0;
        while (done_cnt == done_before && k < 12000) begin @(negedge clk); k++; end
        check(done_cnt == done_before + 1, {nm, "_done"}, done_cnt - done_before, 1);
        repeat (5) @(negedge clk);
        check(done_cnt == done_before + 1, {nm, "_single_done"}, done_cnt - done_before, 1);
        check(!busy && !dht_oe, {nm, "_idle_after"}, {busy, dht_oe}, 0);
        check(seg == 84, {nm, "_seg_count"}, seg, 84);
        check(dec_word == exp_word, {nm, "_model"}, dec_word, exp_word);
        check(dec_word == lit, {nm, "_literal"}, dec_word, lit);
        arm = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int act0, done0;
        fork monitor(); join_none

        repeat (4) @(negedge clk);
        check(!dht_oe, "reset_oe", dht_oe, 0);
        check(!busy, "reset_busy", busy, 0);
        check(!frame_done, "reset_done", frame_done, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        start_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
        finish_frame(40'h37_00_19_00_50, "basic");

        act0 = act_cnt; done0 = done_cnt;
        host_start(100);
        repeat (200 * CLK) @(negedge clk);
        check(act_cnt == act0, "glitch_no_activity", act_cnt - act0, 0);
        check(done_cnt == done0, "glitch_no_frame", done_cnt - done0, 0);

        start_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        finish_frame(40'hFF_FF_FF_FF_FC, "all_ff");
        check(n70 == 38, "all_ff_long_bits", n70, 38);

        start_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
        wait_seg(20);
        set_bytes(8'h11, 8'h11, 8'h11, 8'h11);
        finish_frame(40'h37_00_19_00_50, "snapshot_old");
        start_frame(8'h11, 8'h11, 8'h11, 8'h11, 1'b0);
        finish_frame(40'h11_11_11_11_44, "snapshot_new");

        start_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
        wait_seg(5);
        repeat (10) @(negedge clk);
        check(dht_oe && busy, "bit_low_before_reset", {dht_oe, busy}, 2'b11);
        arm = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check(!dht_oe, "async_reset_oe", dht_oe, 0);
        check(!busy, "async_reset_busy", busy, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        start_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
        finish_frame(40'h37_00_19_00_50, "after_reset");

`ifdef DHT_RESP_CKSUM_ERR_EN
        start_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b1);
        finish_frame(40'h37_00_19_00_AF, "cksum_err");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dht11_responder.md
# dht11_responder

Single-wire DHT11 sensor emulator: the responder end of the protocol that the FPGA's DHT11 controllers initiate. It detects a host start pulse on the shared open-drain line, answers with the standard presence pulse, then serialises 40 bits: humidity, temperature and checksum. It is instantiated in benches, or in a loop-back build in place of a physical sensor on one `pino_inout` line, so that the controller, scheduler and UART path can be exercised without hardware.

## Interface
- `CLK_MHZ`, 50: clock frequency in MHz. One microsecond = `CLK_MHZ` cycles.
- `START_MIN_US`, 18000: minimum host low time accepted as a start request.
- `RESP_DELAY_US`, 30: delay from host release to the start of the presence pulse.
- `clk`  input  1: system clock.
- `rst_n`  input  1: asynchronous, active-low reset.
- `dht_in`  input  1: sampled level of the data line (external pull-up).
- `dht_oe`  output  1: 1 = drive line low; 0 = release. The line is never driven high.
- `hum_int`, `hum_dec`, `temp_int`, `temp_dec`  input  8 each: measurement bytes to report.
- `busy`  output  1: high from accepted start through end of frame.
- `frame_done`  output  1: one-cycle pulse after the final bit's trailing low.

## Operation
- `dht_in` passes through a 2-flop synchroniser. All decisions use the synchronised value.
- A microsecond prescaler (0..`CLK_MHZ`-1) drives a 15-bit µs duration counter. The counter is cleared on every state entry.
- The FSM has these states:
  - **IDLE**: `dht_oe`=0. A falling edge moves to START_LOW.
  - **START_LOW**: counts µs while the line is low.
    - Rising edge with count ≥ `START_MIN_US` → WAIT_REL.
    - Rising edge with count < `START_MIN_US` → IDLE (glitch, ignored).
    - The count saturates and does not wrap.
  - **WAIT_REL**: releases for `RESP_DELAY_US`, then → RESP_LOW. The four data bytes are snapshotted on entry. Checksum = (hum_int+hum_dec+temp_int+temp_dec) mod 256, truncated to 8 bits.
  - **RESP_LOW**: `dht_oe`=1 for 80 µs → RESP_HIGH.
  - **RESP_HIGH**: released for 80 µs → BIT_LOW.
  - **BIT_LOW**: `dht_oe`=1 for 50 µs → BIT_HIGH.
  - **BIT_HIGH**: released for 26 µs (bit 0) or 70 µs (bit 1).
    - Then → BIT_LOW if bits remain.
    - Else → END_LOW.
  - **END_LOW**: `dht_oe`=1 for 50 µs → IDLE. `frame_done` pulses on this exit.
- Bit order is MSB first: hum_int, hum_dec, temp_int, temp_dec, checksum. This is a 40-bit shift register plus a 6-bit bit counter (39..0).
- Input changes after the snapshot do not affect the frame in flight.
- Line activity from WAIT_REL through END_LOW is ignored. There is no collision detection.
- `busy` = state ∉ {IDLE, START_LOW}.

## Timing
- Reset values: `dht_oe`=0, `busy`=0, `frame_done`=0, state IDLE, counters 0, shift register 0.
- Reset asserted mid-frame: `dht_oe` drops to 0 asynchronously. The FSM restarts in IDLE.
- Input latency: 2 cycles of synchroniser delay on every edge detection.
- Durations are exact to ±1 µs tick plus 1 clock.
- Total frame from host release to `frame_done`: `RESP_DELAY_US` + 160 + 40·50 + Σbit-high + 50 µs.
- A line held low past `START_MIN_US` with no release: stays in START_LOW indefinitely. Counter saturates at 32767.

## Configuration
- `DHT_RESP_CKSUM_ERR_EN`:
  - Defined: adds input port `cksum_err` (1 bit), sampled at the WAIT_REL snapshot. When it is 1, the transmitted checksum is the bitwise inverse of the correct value. This is for testing controller error handling.
  - Undefined: the port is absent and the checksum is always correct.

## Test plan
- Reset, then hum=0x37/0x00, temp=0x19/0x00, host low 18 ms and release → after 30 µs: 80 µs low, 80 µs high, then 40 bits decoding 0x37,0x00,0x19,0x00,0x50. `frame_done` pulses once and `busy` falls in the same cycle.
- Host low 10 ms then release → `dht_oe` stays 0 and `busy` stays 0; the FSM returns to IDLE.
- All bytes 0xFF → checksum 0xFC (mod-256 wrap). All 40 bit-high widths are 70 µs, except the checksum's two LSBs at 26 µs.
- Change inputs to 0x11 during the bit phase of a frame → the current frame carries the old values; the next frame carries 0x11.
- Assert `rst_n`=0 during BIT_LOW → `dht_oe`=0 immediately. After release, a new 18 ms start produces a complete, correct frame.
- With `DHT_RESP_CKSUM_ERR_EN` defined and `cksum_err`=1, bytes 0x37/0x00/0x19/0x00 → checksum bits decode 0xAF.
